// File: rtl/button_event_detector.sv
// Per-channel press/release/long-press/auto-repeat event extractor for debounced button levels.
// Optional auto-repeat in LONG is compiled in with BUTTON_AUTO_REPEAT_EN.

module button_event_lane #(
  parameter int LONG_PRESS_CYCLES = 125000000,
  parameter int REPEAT_CYCLES     = 25000000,
  parameter int CNT_WIDTH         = 28
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse,
  output logic repeat_pulse,
  output logic held
);

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit AUTO_REPEAT = 1'b1;
`else
  localparam bit AUTO_REPEAT = 1'b0;
`endif

  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REP_LAST  = CNT_WIDTH'(REPEAT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {S_INIT, S_LOCKOUT, S_IDLE, S_PRESSED, S_LONG} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
  logic                 press_nxt, rel_nxt, long_nxt, rep_nxt, held_nxt;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_INIT;
      cnt              <= '0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      repeat_pulse     <= 1'b0;
      held             <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      press_pulse      <= press_nxt;
      release_pulse    <= rel_nxt;
      long_press_pulse <= long_nxt;
      repeat_pulse     <= rep_nxt;
      held             <= held_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    long_nxt  = 1'b0;
    rep_nxt   = 1'b0;
    case (state)
      // A level already high out of reset is treated as stale, not a press.
      S_INIT: begin
        state_nxt = d ? S_LOCKOUT : S_IDLE;
        cnt_nxt   = '0;
      end
      S_LOCKOUT: if (!d) begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
      S_IDLE: if (d) begin
        state_nxt = S_PRESSED;
        cnt_nxt   = '0;
        press_nxt = 1'b1;
      end
      S_PRESSED: begin
        if (!d) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          rel_nxt   = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_nxt = S_LONG;
          cnt_nxt   = '0;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt_inc;
        end
      end
      S_LONG: begin
        if (!d) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          rel_nxt   = 1'b1;
        end else if (!AUTO_REPEAT) begin
          cnt_nxt   = '0;
        end else if (cnt == REP_LAST) begin
          cnt_nxt   = '0;
          rep_nxt   = 1'b1;
        end else begin
          cnt_nxt   = cnt_inc;
        end
      end
      default: begin
        state_nxt = S_INIT;
        cnt_nxt   = '0;
      end
    endcase
    held_nxt = (state_nxt == S_PRESSED) || (state_nxt == S_LONG);
  end

endmodule

module button_event_detector #(
  parameter int WIDTH             = 1,
  parameter int LONG_PRESS_CYCLES = 125000000,
  parameter int REPEAT_CYCLES     = 25000000,
  parameter int CNT_WIDTH         = $clog2(LONG_PRESS_CYCLES > REPEAT_CYCLES ?
                                           LONG_PRESS_CYCLES : REPEAT_CYCLES) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_press_pulse,
  output logic [WIDTH-1:0] repeat_pulse,
  output logic [WIDTH-1:0] held
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    button_event_lane #(
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
      .REPEAT_CYCLES     (REPEAT_CYCLES),
      .CNT_WIDTH         (CNT_WIDTH)
    ) u_lane (
      .clk              (clk),
      .rst_n            (rst_n),
      .d                (debounced_signal[i]),
      .press_pulse      (press_pulse[i]),
      .release_pulse    (release_pulse[i]),
      .long_press_pulse (long_press_pulse[i]),
      .repeat_pulse     (repeat_pulse[i]),
      .held             (held[i])
    );
  end

endmodule

// File: tb/tb_button_event_detector.sv
// Scoreboard bench for button_event_detector (WIDTH=2, LONG=8, REPEAT=4).
// Expected output vectors are {press,release,long,repeat,held}, 2 bits each.

module tb_button_event_detector;
  localparam int W = 2;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] press, rel, lng, rep, held;

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];

  button_event_detector #(
    .WIDTH(W), .LONG_PRESS_CYCLES(8), .REPEAT_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .debounced_signal(d),
    .press_pulse(press), .release_pulse(rel), .long_press_pulse(lng),
    .repeat_pulse(rep), .held(held)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] ev(input logic [1:0] p, r, l, rp, h);
    return {p, r, l, rp, h};
  endfunction

  // Drive one cycle of stimulus, queue its expected result, capture the DUT's.
  task automatic cyc(input logic [1:0] dv, input logic [9:0] ex);
    @(negedge clk);
    d = dv;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    obs_q.push_back({press, rel, lng, rep, held});
  endtask

  task automatic test_reset();
    logic [9:0] o;
    d = 2'b11;
    repeat (3) begin
      @(posedge clk);
      #1;
      o = {press, rel, lng, rep, held};
      tests++;
      if (o !== 10'd0) begin
        fails++;
        $display("FAIL reset_state: got %b want %b", o, 10'd0);
      end
    end
    @(negedge clk);
    d = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic test_press_release();
    logic [9:0] e, o;
    int n = 0;
    cyc(2'b00, '0);
    cyc(2'b11, ev(2'b11, 0, 0, 0, 2'b11));
    cyc(2'b11, ev(0, 0, 0, 0, 2'b11));
    cyc(2'b11, ev(0, 0, 0, 0, 2'b11));
    cyc(2'b00, ev(0, 2'b11, 0, 0, 0));
    cyc(2'b00, '0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL press_release step %0d: got %b want %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_long_repeat();
    logic [9:0] e, o;
    int n = 0;
    for (int k = 0; k < 20; k++)
      cyc(2'b01, ev((k == 0) ? 2'b01 : 2'b00, 2'b00, (k == 8) ? 2'b01 : 2'b00,
                    (REP_ON && k >= 12 && k % 4 == 0) ? 2'b01 : 2'b00, 2'b01));
    cyc(2'b00, ev(0, 2'b01, 0, 0, 0));
    cyc(2'b00, '0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL long_repeat step %0d: got %b want %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_lockout();
    logic [9:0] e, o;
    int n = 0;
    @(negedge clk);
    d = 2'b01;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    o = {press, rel, lng, rep, held};
    tests++;
    if (o !== 10'd0) begin
      fails++;
      $display("FAIL lockout_reset: got %b want %b", o, 10'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cyc(2'b01, '0);
    cyc(2'b00, '0);
    cyc(2'b01, ev(2'b01, 0, 0, 0, 2'b01));
    cyc(2'b00, ev(0, 2'b01, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL lockout step %0d: got %b want %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_release_on_long();
    logic [9:0] e, o;
    int n = 0;
    for (int k = 0; k < 8; k++)
      cyc(2'b01, ev((k == 0) ? 2'b01 : 2'b00, 0, 0, 0, 2'b01));
    cyc(2'b00, ev(0, 2'b01, 0, 0, 0));
    cyc(2'b00, '0);
    cyc(2'b00, '0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL release_on_long step %0d: got %b want %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e, o;
    int n = 0;
    cyc(2'b01, ev(2'b01, 0, 0, 0, 2'b01));
    cyc(2'b10, ev(2'b10, 2'b01, 0, 0, 2'b10));
    cyc(2'b00, ev(0, 2'b10, 0, 0, 0));
    cyc(2'b11, ev(2'b11, 0, 0, 0, 2'b11));
    cyc(2'b00, ev(0, 2'b11, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL back_to_back step %0d: got %b want %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid_long();
    logic [9:0] e, o;
    int n = 0;
    for (int k = 0; k < 10; k++)
      cyc(2'b11, ev((k == 0) ? 2'b11 : 2'b00, 0, (k == 8) ? 2'b11 : 2'b00, 0, 2'b11));
    // Reset mid-cycle: outputs must clear before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    o = {press, rel, lng, rep, held};
    tests++;
    if (o !== 10'd0) begin
      fails++;
      $display("FAIL async_reset: got %b want %b", o, 10'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc(2'b11, '0);
    cyc(2'b00, '0);
    cyc(2'b11, ev(2'b11, 0, 0, 0, 2'b11));
    cyc(2'b00, ev(0, 2'b11, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset_mid_long step %0d: got %b want %b", n, o, e);
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_long_repeat();
    test_lockout();
    test_release_on_long();
    test_back_to_back();
    test_reset_mid_long();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
